// File: rtl/ir_pkg.sv
// Shared constants for the instruction register / prefetch queue.
package ir_pkg;

  localparam int IR_WIDTH = 16;
  localparam int IR_DEPTH = 4;

  // Reset/flush value of the instruction register (a no-op encoding).
  localparam logic [IR_WIDTH-1:0] IR_NOP = '0;

endpackage

// File: rtl/ir_fifo_mem.sv
// Prefetch FIFO storage with read/write pointers and occupancy count.
// rdata is the head entry, read combinationally; storage is not reset.
module ir_fifo_mem
  import ir_pkg::*;
#(
  parameter int WIDTH = IR_WIDTH,
  parameter int DEPTH = IR_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  // Storage write; callers never push into a full queue.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a prefetch FIFO. ld_ir advances ir_out to the
// next buffered word, bypassing the FIFO when it is empty and a word arrives
// on the same edge. flush empties everything for a branch or jump.
module ir_prefetch_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = IR_WIDTH,
  parameter int DEPTH = IR_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ld_ir,
  input  logic             flush,
  output logic [WIDTH-1:0] ir_out,
  output logic             ir_valid,
  output logic [CNT_W-1:0] count
);

  logic             accept;
  logic             load;
  logic             fifo_empty;
  logic             pop;
  logic             bypass;
  logic             push;
  logic [WIDTH-1:0] head;

  // Readiness depends only on stored state and flush, so a pop from a full
  // queue reopens in_ready only on the following cycle.
  assign in_ready   = (count < CNT_W'(DEPTH)) && !flush;
  assign accept     = in_valid && in_ready;
  assign load       = ld_ir && !flush;
  assign fifo_empty = (count == '0);
  assign pop        = load && !fifo_empty;
  assign bypass     = load && fifo_empty && accept;
  assign push       = accept && !bypass;

  ir_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clr   (flush),
    .wdata (in_data),
    .rdata (head),
    .count (count)
  );

  // Instruction register: flush clears, load takes head or bypassed input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_out   <= WIDTH'(IR_NOP);
      ir_valid <= 1'b0;
    end else if (flush) begin
      ir_out   <= WIDTH'(IR_NOP);
      ir_valid <= 1'b0;
    end else if (load) begin
      if (!fifo_empty) begin
        ir_out   <= head;
        ir_valid <= 1'b1;
      end else if (bypass) begin
        ir_out   <= in_data;
        ir_valid <= 1'b1;
      end else begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Scoreboard bench: stimulus queues the expected ir_out/ir_valid for each
// load; a monitor pops and compares after every load edge.
module tb_ir_prefetch_queue;

  typedef struct {
    logic        valid;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        ld_ir = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic [2:0]  count;

  int total = 0;
  int passed = 0;
  exp_t exp_q[$];

  ir_prefetch_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ld_ir    (ld_ir),
    .flush    (flush),
    .ir_out   (ir_out),
    .ir_valid (ir_valid),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_load(input logic v, input logic [15:0] d);
    exp_t e;
    e.valid = v;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every load edge must match the next scoreboard entry.
  always @(posedge clk) begin
    logic loaded;
    exp_t e;
    loaded = ld_ir && !flush && !rst;
    #1;
    if (loaded) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL load_unexpected: ir_out %0h with no expected entry", ir_out);
      end else begin
        e = exp_q.pop_front();
        chk("load_ir_valid", 32'(ir_valid), 32'(e.valid));
        chk("load_ir_out", 32'(ir_out), 32'(e.data));
      end
    end
  end

  initial begin
    logic [15:0] fill [4];
    fill[0] = 16'h1111; fill[1] = 16'h2222; fill[2] = 16'h3333; fill[3] = 16'h4444;

    #2;
    chk("rst_ir_out", 32'(ir_out), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Fill to full
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = fill[i];
      step();
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'h0);
    in_data = 16'h5555;
    step();
    chk("full_reject_count", 32'(count), 32'd4);

    // Drain: a pop while full must not reopen in_ready in that cycle
    in_valid = 1'b0;
    ld_ir = 1'b1;
    chk("full_pop_in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 4; i++) expect_load(1'b1, fill[i]);
    expect_load(1'b0, 16'h4444);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("drain_count", 32'(count), (i < 4) ? 32'(3 - i) : 32'd0);
    end
    ld_ir = 1'b0;

    // Bypass on empty queue
    in_valid = 1'b1; in_data = 16'hABCD; ld_ir = 1'b1;
    expect_load(1'b1, 16'hABCD);
    step();
    chk("bypass_count", 32'(count), 32'd0);
    ld_ir = 1'b0;

    // Concurrent push and pop at count=2
    in_data = 16'hA001; step();
    in_data = 16'hA002; step();
    chk("conc_pre_count", 32'(count), 32'd2);
    in_data = 16'h7777; ld_ir = 1'b1;
    expect_load(1'b1, 16'hA001);
    step();
    chk("conc_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    expect_load(1'b1, 16'hA002);
    expect_load(1'b1, 16'h7777);
    step();
    step();
    chk("conc_drain_count", 32'(count), 32'd0);
    ld_ir = 1'b0;

    // Flush with input offered and load requested
    in_valid = 1'b1;
    in_data = 16'hB001; step();
    in_data = 16'hB002; step();
    in_data = 16'hB003; step();
    chk("flush_pre_count", 32'(count), 32'd3);
    chk("flush_pre_valid", 32'(ir_valid), 32'h1);
    flush = 1'b1; in_data = 16'hC0DE; ld_ir = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_ir_valid", 32'(ir_valid), 32'h0);
    chk("flush_ir_out", 32'(ir_out), 32'h0);
    flush = 1'b0; ld_ir = 1'b0;
    in_data = 16'hD00D;
    step();
    chk("post_flush_count", 32'(count), 32'd1);
    in_valid = 1'b0; ld_ir = 1'b1;
    expect_load(1'b1, 16'hD00D);
    step();
    ld_ir = 1'b0;

    // Asynchronous reset mid-stream at count=3
    in_valid = 1'b1;
    in_data = 16'hE001; step();
    in_data = 16'hE002; step();
    in_data = 16'hE003; step();
    in_valid = 1'b0;
    chk("rst_pre_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ir_out", 32'(ir_out), 32'h0);
    chk("async_rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("async_rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 16'hF00F;
    step();
    in_valid = 1'b0; ld_ir = 1'b1;
    expect_load(1'b1, 16'hF00F);
    step();
    ld_ir = 1'b0;
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
